// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the IC and LS requesters, the arbiter and the byte-wide RAM.
// The master modport is the requester/RAM side and the slave modport is the arbiter side.
interface mem_arbiter_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_data;
    logic        ls_req;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [1:0]  ls_len;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport slave (
        input  ic_req, ic_addr, ls_req, ls_wr, ls_addr, ls_len, ls_wdata, mem_din,
        output ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output ic_req, ic_addr, ls_req, ls_wr, ls_addr, ls_len, ls_wdata, mem_din,
        input  ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one 8-bit RAM port between instruction fetch and load/store.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise LS always has priority.
module mem_arbiter (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         rob_clear,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, IC_RD, LS_RD, LS_WR, DONE} state_t;

    state_t      state, state_d;
    logic [2:0]  cnt, cnt_d, cnt_inc, ls_n, n_cur;
    logic [1:0]  cap_idx;
    logic [31:0] acc, acc_d, base;
    logic        ic_done_q, ic_done_d, ls_done_q, ls_done_d;
    logic [31:0] ic_data_q, ic_data_d, ls_rdata_q, ls_rdata_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        ls_first;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_ic, last_ic_d, contested, contested_d;
`endif

    always_comb begin
        ls_n    = (bus.ls_len == 2'b00) ? 3'd1 : (bus.ls_len == 2'b01) ? 3'd2 : 3'd4;
        n_cur   = (state == IC_RD) ? 3'd4 : ls_n;
        base    = (state == IC_RD) ? bus.ic_addr : bus.ls_addr;
        cnt_inc = cnt + 3'd1;
        cap_idx = cnt[1:0] - 2'd1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ls_first = last_ic;
`else
        ls_first = 1'b1;
`endif
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        acc_d      = acc;
        ic_data_d  = ic_data_q;
        ls_rdata_d = ls_rdata_q;
        ic_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        mem_a_d    = 32'd0;
        mem_dout_d = 8'd0;
        mem_wr_d   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_ic_d   = last_ic;
        contested_d = contested;
`endif
        case (state)
            IDLE: begin
                if (!rob_clear) begin
                    if (bus.ls_req && (ls_first || !bus.ic_req)) begin
                        state_d    = bus.ls_wr ? LS_WR : LS_RD;
                        cnt_d      = 3'd0;
                        acc_d      = 32'd0;
                        mem_a_d    = bus.ls_addr;
                        mem_wr_d   = bus.ls_wr;
                        mem_dout_d = bus.ls_wr ? bus.ls_wdata[7:0] : 8'd0;
                    end else if (bus.ic_req) begin
                        state_d = IC_RD;
                        cnt_d   = 3'd0;
                        acc_d   = 32'd0;
                        mem_a_d = bus.ic_addr;
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    contested_d = bus.ic_req && bus.ls_req;
`endif
                end
            end
            IC_RD, LS_RD: begin
                if (rob_clear) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    // RAM data lags the address by one cycle: byte cnt-1 arrives now.
                    if (cnt != 3'd0) acc_d[{cap_idx, 3'b000} +: 8] = bus.mem_din;
                    cnt_d = cnt_inc;
                    if (cnt_inc < n_cur) mem_a_d = base + {29'd0, cnt_inc};
                    if (cnt == n_cur) begin
                        state_d = DONE;
                        cnt_d   = 3'd0;
                        if (state == IC_RD) begin
                            ic_data_d = acc_d;
                            ic_done_d = 1'b1;
                        end else begin
                            ls_rdata_d = acc_d;
                            ls_done_d  = 1'b1;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        if (contested) last_ic_d = (state == IC_RD);
`endif
                    end
                end
            end
            LS_WR: begin
                if (cnt_inc < n_cur) begin
                    cnt_d      = cnt_inc;
                    mem_a_d    = base + {29'd0, cnt_inc};
                    mem_wr_d   = 1'b1;
                    mem_dout_d = bus.ls_wdata[{cnt_inc[1:0], 3'b000} +: 8];
                end else begin
                    state_d   = DONE;
                    cnt_d     = 3'd0;
                    ls_done_d = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (contested) last_ic_d = 1'b0;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            acc        <= 32'd0;
            ic_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            ic_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ic    <= 1'b1;
            contested  <= 1'b0;
`endif
        end else if (rdy_in) begin
            state      <= state_d;
            cnt        <= cnt_d;
            acc        <= acc_d;
            ic_done_q  <= ic_done_d;
            ls_done_q  <= ls_done_d;
            ic_data_q  <= ic_data_d;
            ls_rdata_q <= ls_rdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ic    <= last_ic_d;
            contested  <= contested_d;
`endif
        end
    end

    // A stalled write cycle must not strobe the RAM, so the strobe is gated by rdy_in.
    assign bus.mem_wr   = mem_wr_q & rdy_in;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.ic_done  = ic_done_q;
    assign bus.ic_data  = ic_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, directed scenarios, then random traffic.
// The RAM model registers its read data only on rdy_in cycles, so a global stall freezes it as well.
module tb_mem_arbiter;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;
    logic rob_clear = 1'b0;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .rob_clear (rob_clear),
        .bus       (bus)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] ram [256];
    logic [7:0] din_q = 8'd0;
    logic       init_en = 1'b1;
    logic [7:0] init_a = 8'd0;
    logic [7:0] init_d = 8'd0;

    always @(posedge clk_in) begin
        if (init_en) ram[init_a] <= init_d;
        else if (rdy_in) begin
            din_q <= ram[bus.mem_a[7:0]];
            if (bus.mem_wr) ram[bus.mem_a[7:0]] <= bus.mem_dout;
        end
    end
    assign bus.mem_din = din_q;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 busy, 2 done; kind 0 IC read, 1 LS read, 2 LS write.
    logic [7:0]  ref_mem [256];
    int          m_phase, m_kind, m_n, m_t;
    logic [31:0] m_base, m_wdata;
    bit          m_contested, m_last_ic, m_done_new;
    logic        e_ic_done, e_ls_done;
    logic [31:0] e_ic_data, e_ls_rdata;
    bit          ic_pend, ls_pend;
    bit          seen;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_kind = 0; m_n = 0; m_t = 0;
        m_base = 32'd0; m_wdata = 32'd0;
        m_contested = 1'b0; m_last_ic = 1'b1; m_done_new = 1'b0;
        e_ic_done = 1'b0; e_ls_done = 1'b0; e_ic_data = 32'd0; e_ls_rdata = 32'd0;
    endtask

    function automatic logic [31:0] ref_read(logic [31:0] a, int n);
        logic [31:0] r, ak;
        r = 32'd0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            r[8*k +: 8] = ref_mem[ak[7:0]];
        end
        return r;
    endfunction

    task automatic model_complete();
        m_phase = 2;
        m_done_new = 1'b1;
        if (m_kind == 0) begin
            e_ic_done = 1'b1;
            e_ic_data = ref_read(m_base, 4);
        end else begin
            e_ls_done = 1'b1;
            if (m_kind == 1) e_ls_rdata = ref_read(m_base, m_n);
        end
        if (m_contested) m_last_ic = (m_kind == 0);
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic model_edge();
        bit take_ls;
        logic [31:0] wa;
        m_done_new = 1'b0;
        if (!rst_in) begin
            model_reset();
            return;
        end
        if (!rdy_in) return;
        e_ic_done = 1'b0;
        e_ls_done = 1'b0;
        case (m_phase)
            2: m_phase = 0;
            0: if (!rob_clear && (bus.ic_req || bus.ls_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                take_ls = bus.ls_req && (!bus.ic_req || m_last_ic);
`else
                take_ls = bus.ls_req;
`endif
                m_contested = bus.ic_req && bus.ls_req;
                m_phase = 1;
                m_t = 0;
                if (take_ls) begin
                    m_kind  = bus.ls_wr ? 2 : 1;
                    m_base  = bus.ls_addr;
                    m_wdata = bus.ls_wdata;
                    m_n     = (bus.ls_len == 2'd0) ? 1 : (bus.ls_len == 2'd1) ? 2 : 4;
                end else begin
                    m_kind = 0;
                    m_base = bus.ic_addr;
                    m_n    = 4;
                end
            end
            default: begin
                if (m_kind == 2) begin
                    wa = m_base + 32'(m_t);
                    ref_mem[wa[7:0]] = m_wdata[8*m_t +: 8];
                    m_t++;
                    if (m_t == m_n) model_complete();
                end else if (rob_clear) begin
                    m_phase = 0;
                end else begin
                    m_t++;
                    if (m_t == m_n + 1) model_complete();
                end
            end
        endcase
    endtask

    function automatic logic exp_wr_f();
        return (m_phase == 1) && (m_kind == 2);
    endfunction

    task automatic compare_regs();
        logic [31:0] ea;
        logic [7:0]  ed;
        ea = 32'd0;
        ed = 8'd0;
        if (m_phase == 1) begin
            if (m_kind == 2) begin
                ea = m_base + 32'(m_t);
                ed = m_wdata[8*m_t +: 8];
            end else if (m_t < m_n) begin
                ea = m_base + 32'(m_t);
            end
        end
        chk("ic_done",  32'(bus.ic_done),  32'(e_ic_done));
        chk("ls_done",  32'(bus.ls_done),  32'(e_ls_done));
        chk("ic_data",  bus.ic_data,       e_ic_data);
        chk("ls_rdata", bus.ls_rdata,      e_ls_rdata);
        chk("mem_a",    bus.mem_a,         ea);
        chk("mem_dout", 32'(bus.mem_dout), 32'(ed));
    endtask

    // One clock: check the gated strobe mid-cycle, then cross the edge and compare registered outputs.
    task automatic step();
        #1;
        chk("mem_wr", 32'(bus.mem_wr), 32'(exp_wr_f() & rdy_in));
        @(posedge clk_in);
        #1;
        model_edge();
        compare_regs();
    endtask

    task automatic drop_reqs();
        bus.ic_req = 1'b0;
        bus.ls_req = 1'b0;
        bus.ls_wr  = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        if ($urandom_range(3) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(3));
        return $urandom;
    endfunction

    task automatic check_all_zero(string tag);
        chk({tag, "_ic_done"},  32'(bus.ic_done),  32'd0);
        chk({tag, "_ls_done"},  32'(bus.ls_done),  32'd0);
        chk({tag, "_ic_data"},  bus.ic_data,       32'd0);
        chk({tag, "_ls_rdata"}, bus.ls_rdata,      32'd0);
        chk({tag, "_mem_a"},    bus.mem_a,         32'd0);
        chk({tag, "_mem_dout"}, 32'(bus.mem_dout), 32'd0);
        chk({tag, "_mem_wr"},   32'(bus.mem_wr),   32'd0);
    endtask

    initial begin
        bus.ic_req = 1'b0; bus.ic_addr = 32'd0;
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_addr = 32'd0;
        bus.ls_len = 2'd0; bus.ls_wdata = 32'd0;
        model_reset();

        for (int i = 0; i < 256; i++) begin
            init_a = 8'(i);
            case (i)
                0: init_d = 8'h13;  1: init_d = 8'h05;
                2: init_d = 8'h00;  3: init_d = 8'h00;
                16: init_d = 8'h11; 17: init_d = 8'h22;
                18: init_d = 8'h33; 19: init_d = 8'h44;
                default: init_d = 8'($urandom);
            endcase
            ref_mem[i] = init_d;
            @(posedge clk_in);
            #1;
        end
        init_en = 1'b0;
        check_all_zero("reset");
        rst_in = 1'b1;
        rdy_in = 1'b1;

        // IC fetch of 0x100 assembles 13 05 00 00 little-endian.
        bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
        step();
        chk("s1_a0", bus.mem_a, 32'h100);
        repeat (3) step();
        chk("s1_a3", bus.mem_a, 32'h103);
        step();
        chk("s1_early", 32'(bus.ic_done), 32'd0);
        step();
        chk("s1_done", 32'(bus.ic_done), 32'd1);
        chk("s1_data", bus.ic_data, 32'h0000_0513);
        chk("s1_model", e_ic_data, 32'h0000_0513);
        bus.ic_req = 1'b0;
        step();

        // Halfword store crossing 0x1FFF -> 0x2000.
        bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_len = 2'b01;
        bus.ls_addr = 32'h1FFF; bus.ls_wdata = 32'h0000_BEEF;
        step();
        chk("s2_a0", bus.mem_a, 32'h1FFF);
        chk("s2_d0", 32'(bus.mem_dout), 32'hEF);
        step();
        chk("s2_a1", bus.mem_a, 32'h2000);
        chk("s2_d1", 32'(bus.mem_dout), 32'hBE);
        step();
        chk("s2_done", 32'(bus.ls_done), 32'd1);
        chk("s2_ram", {16'd0, ram[8'h00], ram[8'hFF]}, 32'h0000_BEEF);
        drop_reqs();
        step();

        // Simultaneous requests, three rounds.
        for (int r = 0; r < 3; r++) begin
            bit exp_ls;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_ls = (r != 1);
`else
            exp_ls = 1'b1;
`endif
            bus.ic_req = 1'b1; bus.ic_addr = 32'h400 + 32'(4 * r);
            bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_len = 2'b10; bus.ls_addr = 32'h500;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                step();
                seen = bus.ic_done || bus.ls_done;
            end
            chk("s3_seen", 32'(seen), 32'd1);
            chk("s3_winner", 32'(bus.ls_done), 32'(exp_ls));
            chk("s3_model", 32'(e_ls_done), 32'(exp_ls));
            drop_reqs();
            step();
        end

        // Flush in A+2 of a fetch; the waiting load is granted in the IDLE cycle that follows.
        bus.ic_req = 1'b1; bus.ic_addr = 32'h240;
        step();
        bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_len = 2'b10; bus.ls_addr = 32'h310;
        step();
        step();
        rob_clear = 1'b1;
        step();
        chk("s4_nodone", 32'(bus.ic_done), 32'd0);
        chk("s4_idle_a", bus.mem_a, 32'd0);
        rob_clear = 1'b0;
        bus.ic_req = 1'b0;
        step();
        chk("s4_ls_a0", bus.mem_a, 32'h310);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            seen = bus.ls_done;
        end
        chk("s4_seen", 32'(seen), 32'd1);
        chk("s4_rdata", bus.ls_rdata, 32'h4433_2211);
        drop_reqs();
        step();

        // Flush during a word store is ignored.
        bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_len = 2'b10;
        bus.ls_addr = 32'h850; bus.ls_wdata = 32'hA1B2_C3D4;
        step();
        step();
        rob_clear = 1'b1;
        step();
        step();
        rob_clear = 1'b0;
        chk("s5_a3", bus.mem_a, 32'h853);
        step();
        chk("s5_done", 32'(bus.ls_done), 32'd1);
        chk("s5_ram", {ram[8'h53], ram[8'h52], ram[8'h51], ram[8'h50]}, 32'hA1B2_C3D4);
        drop_reqs();
        step();

        // Three stall cycles mid-load delay completion by three.
        bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_len = 2'b10; bus.ls_addr = 32'h310;
        step();
        step();
        rdy_in = 1'b0;
        step(); step(); step();
        rdy_in = 1'b1;
        step(); step(); step();
        chk("s6_early", 32'(bus.ls_done), 32'd0);
        step();
        chk("s6_done", 32'(bus.ls_done), 32'd1);
        chk("s6_rdata", bus.ls_rdata, 32'h4433_2211);
        drop_reqs();
        step();

        // Reset pulsed in the middle of a fetch.
        bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
        step();
        step();
        #2;
        rst_in = 1'b0;
        #1;
        check_all_zero("s6_rst");
        model_reset();
        bus.ic_req = 1'b0;
        step();
        rst_in = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("s6_quiet", 32'(bus.ic_done | bus.ls_done), 32'd0);
        end

        // Random traffic.
        ic_pend = 1'b0;
        ls_pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (m_done_new && e_ic_done) ic_pend = 1'b0;
            if (m_done_new && e_ls_done) ls_pend = 1'b0;
            if (!ic_pend) begin
                bus.ic_addr = pick_addr();
                bus.ic_req  = ($urandom_range(2) == 0);
                ic_pend     = bus.ic_req;
            end
            if (!ls_pend) begin
                bus.ls_wr    = 1'($urandom_range(1));
                bus.ls_len   = 2'($urandom_range(3));
                bus.ls_addr  = pick_addr();
                bus.ls_wdata = $urandom;
                bus.ls_req   = ($urandom_range(2) == 0);
                ls_pend      = bus.ls_req;
            end
            rdy_in    = ($urandom_range(7) != 0);
            rob_clear = ($urandom_range(9) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose these ports, one per line: name  direction  width  meaning.
  clk_in  in  1  sole clock, rising edge.
  rst_in  in  1  reset, asynchronous, active-low.
  rdy_in  in  1  global stall; low freezes all state.
  rob_clear  in  1  misprediction flush.
  ic_req  in  1  instruction cache requests a 4-byte read.
  ic_addr  in  32  instruction read byte address.
  ic_done  out  1  one-cycle pulse: ic_data valid.
  ic_data  out  32  assembled instruction word, little-endian.
  ls_req  in  1  load/store buffer request.
  ls_wr  in  1  1 = store, 0 = load.
  ls_addr  in  32  load/store byte address.
  ls_len  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes; 11 is illegal.
  ls_wdata  in  32  store data; low ls_len bytes are used.
  ls_done  out  1  one-cycle pulse: access complete.
  ls_rdata  out  32  load data, zero-extended.
  mem_din  in  8  RAM read byte for the address driven in the previous cycle.
  mem_dout  out  8  RAM write byte.
  mem_a  out  32  RAM byte address.
  mem_wr  out  1  RAM write strobe.
REQ-002 Requesters SHALL hold req and all request fields stable from assertion until the matching done pulse.

Function
REQ-003 FSM states SHALL be IDLE, IC_RD, LS_RD, LS_WR and DONE.
REQ-004 In IDLE, the block SHALL sample requests and grant one requester.
REQ-005 On grant, state SHALL become IC_RD, LS_RD or LS_WR, and the byte counter SHALL clear to 0.
REQ-006 Byte count n SHALL be 4 for IC reads and 1/2/4 from ls_len for LS accesses.
REQ-007 mem_a, mem_dout and mem_wr SHALL be registered.
REQ-008 The first address cycle A SHALL be the cycle after grant; mem_a SHALL equal base+k in cycle A+k, for k = 0..n-1.
REQ-009 Address arithmetic SHALL wrap modulo 2^32; unaligned addresses are legal.
REQ-010 Reads: the byte on mem_din in cycle A+k+1 SHALL be captured into bits [8k+7:8k] of the result.
REQ-011 Reads: done SHALL pulse in cycle A+n+1.
REQ-012 Writes: mem_wr SHALL be 1 and mem_dout SHALL equal ls_wdata[8k+7:8k] in cycle A+k.
REQ-013 Writes: done SHALL pulse in cycle A+n.
REQ-014 Completion SHALL pass through DONE, which raises the done pulse, ignores requests and returns to IDLE.
REQ-015 Consequently, the earliest next grant SHALL be the cycle after done.
REQ-016 ic_data and ls_rdata SHALL hold their last value until the next completion of the same requester.
REQ-017 Outside write cycles, mem_wr SHALL be 0; in IDLE and DONE, mem_a and mem_dout SHALL be 0.
REQ-018 rob_clear in IC_RD or LS_RD SHALL abort the access: next state IDLE, no done pulse, result registers unchanged.
REQ-019 rob_clear in LS_WR SHALL be ignored; a committed store always completes.
REQ-020 rob_clear in IDLE SHALL block grants that cycle.
REQ-021 rob_clear in DONE SHALL not cancel the done pulse.
REQ-022 While rdy_in=0, all registers SHALL hold, and mem_wr SHALL be forced to 0 combinationally.
REQ-023 On resumption, the sequence SHALL continue where it stopped.
REQ-024 ls_len=11 SHALL be treated as 4 bytes.

Reset
REQ-025 When rst_in=0, the block SHALL immediately, independent of clk_in, enter IDLE.
REQ-026 When rst_in=0, the byte counter SHALL clear.
REQ-027 When rst_in=0, these outputs SHALL clear to 0: ic_done, ls_done, ic_data, ls_rdata, mem_a, mem_dout, mem_wr.
REQ-028 When rst_in=0, the round-robin pointer SHALL become "last served = IC".
REQ-029 Reset mid-access SHALL abandon the access without any done pulse.
REQ-030 Normal operation SHALL start on the first rising edge after rst_in rises.

Configuration
REQ-031 With MEM_ARB_ROUND_ROBIN_EN undefined, LS SHALL win every simultaneous request.
REQ-032 With MEM_ARB_ROUND_ROBIN_EN defined, a simultaneous request SHALL go to the requester not served last.
REQ-033 With MEM_ARB_ROUND_ROBIN_EN defined, the pointer SHALL update on each grant that is not aborted.
REQ-034 With MEM_ARB_ROUND_ROBIN_EN defined, the pointer SHALL be unchanged by single-requester grants.
REQ-035 Both builds SHALL keep identical ports and timing.

Verification
REQ-036 Scenario: ic_req with ic_addr=0x100, RAM bytes 13,05,00,00 -> mem_a = 0x100..0x103 in A..A+3; ic_done in A+5; ic_data=0x00000513.
REQ-037 Scenario: ls store, ls_len=01, ls_addr=0x1FFF, ls_wdata=0xBEEF -> writes EF to 0x1FFF then BE to 0x2000; ls_done in A+2.
REQ-038 Scenario: ic_req and ls_req in the same cycle, repeated -> default build serves LS each time; round-robin build alternates LS, IC, LS.
REQ-039 Scenario: rob_clear in cycle A+2 of an IC read -> no ic_done; IDLE next cycle; pending ls load granted the following cycle.
REQ-040 Scenario: rob_clear during a 4-byte store -> all 4 bytes written; ls_done in A+4.
REQ-041 Scenario: rdy_in low for 3 cycles mid-load, then rst_in pulsed low mid-access -> load completes 3 cycles late with correct data; after reset, all outputs are 0 and no done pulse occurs.
